// File: rtl/platform_anim_if.sv
// Signal bundle between the game-state logic and the platform animation sequencer.
// The slave side is the sequencer; the master side is whoever drives game state and video timing.
interface platform_anim_if;
   logic       start_game;
   logic       vblnk;
   logic       freeze;
   logic       animation;
   logic [3:0] platform_mask;
   logic       anim_done;
   logic       busy;

   modport master (
      output start_game, vblnk, freeze,
      input  animation, platform_mask, anim_done, busy
   );

   modport slave (
      input  start_game, vblnk, freeze,
      output animation, platform_mask, anim_done, busy
   );
endinterface

// File: rtl/platform_anim_ctrl.sv
// Platform reveal sequencer: uncovers platforms bottom-up one step at a time,
// holds the full layout for a fixed number of frames, then pulses anim_done.
module platform_anim_ctrl #(
   parameter int FRAMES_PER_STEP = 30,
   parameter int HOLD_FRAMES     = 60,
   parameter int NUM_PLATFORMS   = 4
) (
   input  logic           clk,
   input  logic           rst,
   platform_anim_if.slave bus
);

   localparam int MAX_FRAMES = (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

   localparam logic [CNT_W-1:0]         STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
   localparam logic [CNT_W-1:0]         HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
   localparam logic [CNT_W-1:0]         CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
   localparam logic [NUM_PLATFORMS-1:0] MASK_NONE  = NUM_PLATFORMS'(0);
   localparam logic [NUM_PLATFORMS-1:0] MASK_FIRST = NUM_PLATFORMS'(1);
   localparam logic [NUM_PLATFORMS-1:0] MASK_ALL   = {NUM_PLATFORMS{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REVEAL = 2'd1,
      ST_HOLD   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                   state_r, state_s;
   logic [CNT_W-1:0]         cnt_r, cnt_s;
   logic [NUM_PLATFORMS-1:0] mask_r, mask_s;
   logic                     anim_r, anim_s;
   logic                     done_r, done_s;
   logic                     busy_r, busy_s;
   logic                     vblnk_q_r;
   logic                     start_q_r;
   logic                     tick_s;
   logic                     start_rise_s;

   // Ticks seen while frozen are dropped, not deferred.
   assign tick_s       = bus.vblnk & ~vblnk_q_r & ~bus.freeze;
   assign start_rise_s = bus.start_game & ~start_q_r;

   // Edge-detect history for vblnk and start_game.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q_r <= 1'b0;
         start_q_r <= 1'b0;
      end else begin
         vblnk_q_r <= bus.vblnk;
         start_q_r <= bus.start_game;
      end
   end

   // State, frame counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         mask_r  <= MASK_NONE;
         anim_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         mask_r  <= mask_s;
         anim_r  <= anim_s;
         done_r  <= done_s;
         busy_r  <= busy_s;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      mask_s  = mask_r;
      anim_s  = anim_r;
      busy_s  = busy_r;
      done_s  = 1'b0;

      // Dropping start_game aborts silently and outranks any tick this cycle.
      if ((state_r != ST_IDLE) && !bus.start_game) begin
         state_s = ST_IDLE;
         cnt_s   = CNT_ZERO;
         mask_s  = MASK_NONE;
         anim_s  = 1'b0;
         busy_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_rise_s) begin
                  state_s = ST_REVEAL;
                  cnt_s   = CNT_ZERO;
                  mask_s  = MASK_FIRST;
                  anim_s  = 1'b1;
                  busy_s  = 1'b1;
               end else begin
                  cnt_s   = CNT_ZERO;
                  mask_s  = MASK_NONE;
                  anim_s  = 1'b0;
                  busy_s  = 1'b0;
               end
            end

            ST_REVEAL: begin
               if (tick_s) begin
                  if (cnt_r == STEP_LAST) begin
                     cnt_s = CNT_ZERO;
                     if (mask_r == MASK_ALL) begin
                        state_s = ST_HOLD;
                     end else begin
                        mask_s = {mask_r[NUM_PLATFORMS-2:0], 1'b1};
                     end
                  end else begin
                     cnt_s = cnt_r + CNT_ONE;
                  end
               end else begin
                  cnt_s = cnt_r;
               end
            end

            ST_HOLD: begin
               mask_s = MASK_ALL;
               anim_s = 1'b1;
               if (tick_s) begin
                  if (cnt_r == HOLD_LAST) begin
                     state_s = ST_DONE;
                     cnt_s   = CNT_ZERO;
                     done_s  = 1'b1;
                     busy_s  = 1'b0;
                  end else begin
                     cnt_s = cnt_r + CNT_ONE;
                  end
               end else begin
                  cnt_s = cnt_r;
               end
            end

            ST_DONE: begin
               mask_s = MASK_ALL;
               anim_s = 1'b1;
               busy_s = 1'b0;
            end

            default: begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
               mask_s  = MASK_NONE;
               anim_s  = 1'b0;
               busy_s  = 1'b0;
            end
         endcase
      end
   end

   assign bus.animation     = anim_r;
   assign bus.platform_mask = mask_r;
   assign bus.anim_done     = done_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_platform_anim_ctrl.sv
// Scoreboard bench for platform_anim_ctrl with FRAMES_PER_STEP=2, HOLD_FRAMES=3.
// Output vector is {animation, platform_mask[3:0], anim_done, busy}.
module tb_platform_anim_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   platform_anim_if bus();

   platform_anim_ctrl #(
      .FRAMES_PER_STEP(2),
      .HOLD_FRAMES    (3),
      .NUM_PLATFORMS  (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [6:0] val;
      int         cyc;
      int         id;
      bit         probe;
   } exp_t;

   localparam logic [6:0] O_IDLE = 7'b0_0000_0_0;
   localparam logic [6:0] O_M1   = 7'b1_0001_0_1;
   localparam logic [6:0] O_M2   = 7'b1_0011_0_1;
   localparam logic [6:0] O_M3   = 7'b1_0111_0_1;
   localparam logic [6:0] O_M4   = 7'b1_1111_0_1;
   localparam logic [6:0] O_DNP  = 7'b1_1111_1_0;
   localparam logic [6:0] O_DN   = 7'b1_1111_0_0;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   id_n = 0;
   bit   stop_req = 1'b0;

   wire [6:0] dut_o = {bus.animation, bus.platform_mask, bus.anim_done, bus.busy};

   task automatic push(input logic [6:0] v, input int c, input bit probe);
      exp_t e;
      e.val = v; e.cyc = c; e.id = id_n; e.probe = probe;
      sb.push_back(e);
      id_n = id_n + 1;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic tick(input bit ch, input logic [6:0] v);
      step();
      bus.vblnk = 1'b1;
      if (ch) push(v, cyc + 1, 1'b0);
      step();
      bus.vblnk = 1'b0;
   endtask

   task automatic tick_done();
      step();
      bus.vblnk = 1'b1;
      push(O_DNP, cyc + 1, 1'b0);
      push(O_DN,  cyc + 2, 1'b0);
      step();
      bus.vblnk = 1'b0;
   endtask

   task automatic set_start(input logic v, input logic [6:0] o);
      step();
      bus.start_game = v;
      push(o, cyc + 1, 1'b0);
   endtask

   // Monitor: every output change (or scheduled probe) is checked against the queue head.
   initial begin : monitor
      logic [6:0] cur;
      logic [6:0] prev_o;
      exp_t       e;
      prev_o = O_IDLE;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (stop_req) begin
            total = total + 1;
            if (sb.size() != 0) begin
               bad = bad + 1;
               $display("FAIL leftover got=%0d pending exp=0 pending (first id=%0d)", sb.size(), sb[0].id);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
         cur = dut_o;
         if ((cur !== prev_o) || ((sb.size() != 0) && sb[0].probe && (sb[0].cyc == cyc))) begin
            total = total + 1;
            if (sb.size() == 0) begin
               bad = bad + 1;
               $display("FAIL unexpected_change cyc=%0d got=%b exp=%b", cyc, cur, prev_o);
            end else begin
               e = sb.pop_front();
               if ((cur !== e.val) || (cyc != e.cyc)) begin
                  bad = bad + 1;
                  $display("FAIL chk%0d got=%b@cyc%0d exp=%b@cyc%0d", e.id, cur, cyc, e.val, e.cyc);
               end
            end
         end
         prev_o = cur;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      rst = 1'b1;
      bus.start_game = 1'b0;
      bus.vblnk = 1'b0;
      bus.freeze = 1'b0;
      step();
      push(O_IDLE, cyc + 1, 1'b1);
      step();
      step();
      rst = 1'b0;
      repeat (3) step();

      // Basic reveal: 4 steps of 2 ticks, then 3 hold ticks.
      set_start(1'b1, O_M1);
      tick(1'b0, O_IDLE); tick(1'b1, O_M2);
      tick(1'b0, O_IDLE); tick(1'b1, O_M3);
      tick(1'b0, O_IDLE); tick(1'b1, O_M4);
      repeat (4) tick(1'b0, O_IDLE);
      tick_done();
      // DONE persists through further frames.
      repeat (50) tick(1'b0, O_IDLE);
      set_start(1'b0, O_IDLE);
      repeat (2) step();

      // Abort at mask 0011, then restart from 0001.
      set_start(1'b1, O_M1);
      tick(1'b0, O_IDLE); tick(1'b1, O_M2); tick(1'b0, O_IDLE);
      set_start(1'b0, O_IDLE);
      step();
      set_start(1'b1, O_M1);

      // Freeze mid-step at mask 0011; frozen ticks are lost.
      tick(1'b0, O_IDLE); tick(1'b1, O_M2); tick(1'b0, O_IDLE);
      step();
      bus.freeze = 1'b1;
      repeat (5) tick(1'b0, O_IDLE);
      step();
      bus.freeze = 1'b0;
      tick(1'b1, O_M3); tick(1'b0, O_IDLE); tick(1'b1, O_M4);
      repeat (4) tick(1'b0, O_IDLE);
      tick_done();
      set_start(1'b0, O_IDLE);
      repeat (2) step();

      // start rise coincident with vblnk rise: that tick is not counted.
      step();
      bus.start_game = 1'b1;
      bus.vblnk = 1'b1;
      push(O_M1, cyc + 1, 1'b0);
      step();
      bus.vblnk = 1'b0;
      step();
      // vblnk held high for 100 clocks counts once.
      step();
      bus.vblnk = 1'b1;
      repeat (100) step();
      bus.vblnk = 1'b0;
      step();
      tick(1'b1, O_M2);
      tick(1'b0, O_IDLE); tick(1'b1, O_M3);
      tick(1'b0, O_IDLE); tick(1'b1, O_M4);
      repeat (3) tick(1'b0, O_IDLE);

      // Reset mid-HOLD with start_game held high: restart right after reset.
      step();
      rst = 1'b1;
      push(O_IDLE, cyc + 1, 1'b0);
      step();
      push(O_IDLE, cyc + 1, 1'b1);
      step();
      rst = 1'b0;
      push(O_M1, cyc + 1, 1'b0);
      tick(1'b0, O_IDLE); tick(1'b1, O_M2);
      tick(1'b0, O_IDLE); tick(1'b1, O_M3);
      tick(1'b0, O_IDLE); tick(1'b1, O_M4);
      repeat (4) tick(1'b0, O_IDLE);
      tick_done();
      set_start(1'b0, O_IDLE);
      repeat (3) step();

      stop_req = 1'b1;
   end

endmodule
